nco_phase_sched: RTL and testbench



---
 rtl/nco_phase_sched.sv | 199 +++++++++++++++++++
 tb/tb_nco_phase_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_sched.sv
`default_nettype none
// =============================================================================
// Module      : nco_phase_sched
// Description : Time-multiplexes one externally pipelined N-bit phase adder
//               between CH NCO channels. Holds every channel's phase
//               accumulator and frequency tuning word (FTW), issues at most
//               one accumulate per clock in round-robin order, tracks the
//               in-flight operations through the adder latency and writes the
//               returned sums back as the new channel phases.
//
// Parameters  : N       - phase / FTW width
//               CH      - number of channels (2..16)
//               CHW     - channel index width, ceil(log2(CH))
//               ADD_LAT - clocks from add_a_out/add_b_out to add_sum_in (1..8)
//
// Ports       : clk, rst            clock, asynchronous active-high reset
//               en                  issue enable (in-flight ops always drain)
//               phase_clr           synchronous clear of all phases
//               ftw_wr/ch/data      FTW write request, held until ftw_ack
//               ftw_ack             one-cycle write acknowledge
//               add_a_out/add_b_out adder operands (phase, FTW)
//               add_sum_in          adder result, carry discarded
//               phase_out/phase_ch  updated phase and its channel
//               phase_valid         phase_out/phase_ch valid this cycle
//
// Options     : CH_MASK_EN - adds input ch_mask[CH-1:0]; channels whose mask
//               bit is 0 are never issued and the pointer skips them.
//
// Revision    : 1.0 - initial release
// =============================================================================
module nco_phase_sched #(
    parameter int N       = 32,
    parameter int CH      = 4,
    parameter int CHW     = 2,
    parameter int ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           phase_clr,
    input  logic           ftw_wr,
    input  logic [CHW-1:0] ftw_ch,
    input  logic [N-1:0]   ftw_data,
    output logic           ftw_ack,
    output logic [N-1:0]   add_a_out,
    output logic [N-1:0]   add_b_out,
    input  logic [N-1:0]   add_sum_in,
    output logic [N-1:0]   phase_out,
    output logic [CHW-1:0] phase_ch,
    output logic           phase_valid
`ifdef CH_MASK_EN
    ,
    input  logic [CH-1:0]  ch_mask
`endif
);

    localparam logic [CHW-1:0] c_LAST_CH = CHW'(CH - 1);

    // Channel state
    logic [N-1:0]   r_phase [CH];
    logic [N-1:0]   r_ftw   [CH];
    logic [CHW-1:0] r_ptr;

    // Tag pipe. Stage 0 is loaded together with the operand registers;
    // stage ADD_LAT lines up with add_sum_in.
    logic [ADD_LAT:0] r_tag_vld;
    logic [CHW-1:0]   r_tag_ch [ADD_LAT+1];

    // Output registers
    logic           r_ftw_ack;
    logic [N-1:0]   r_add_a;
    logic [N-1:0]   r_add_b;
    logic [N-1:0]   r_phase_out;
    logic [CHW-1:0] r_phase_ch;
    logic           r_phase_valid;

    // Scheduling
    logic [CH-1:0]  w_busy;
    logic [CH-1:0]  w_elig;
    logic [CHW-1:0] w_idx;
    logic [CHW-1:0] w_sel;
    logic           w_found;
    logic           w_do_issue;
    logic           w_wb;
    logic [CHW-1:0] w_wb_ch;
    logic [N-1:0]   w_op_a;
    logic           w_ftw_take;

    assign ftw_ack     = r_ftw_ack;
    assign add_a_out   = r_add_a;
    assign add_b_out   = r_add_b;
    assign phase_out   = r_phase_out;
    assign phase_ch    = r_phase_ch;
    assign phase_valid = r_phase_valid;

    assign w_wb    = r_tag_vld[ADD_LAT];
    assign w_wb_ch = r_tag_ch[ADD_LAT];

    // A channel is busy while its tag sits in stages 0..ADD_LAT-1. The final
    // stage is being written back this cycle, so that channel may be
    // re-issued using the returning sum (see w_op_a), which gives the
    // ADD_LAT+1 revisit period when CH <= ADD_LAT.
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < ADD_LAT; k++) begin
            if (r_tag_vld[k]) begin
                w_busy[r_tag_ch[k]] = 1'b1;
            end
        end
    end

`ifdef CH_MASK_EN
    assign w_elig = ~w_busy & ch_mask;
`else
    assign w_elig = ~w_busy;
`endif

    // First eligible channel at or after the pointer. Scanning from the far
    // end lets the last hit be the nearest one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            w_idx = CHW'((int'(r_ptr) + i) % CH);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_do_issue = en && !phase_clr && w_found;

    // Forward the sum being written back when the same channel is re-issued.
    assign w_op_a = (w_wb && (w_wb_ch == w_sel)) ? add_sum_in : r_phase[w_sel];

    assign w_ftw_take = ftw_wr && !r_ftw_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                r_phase[c] <= '0;
                r_ftw[c]   <= '0;
            end
            for (int k = 0; k <= ADD_LAT; k++) begin
                r_tag_ch[k] <= '0;
            end
            r_tag_vld     <= '0;
            r_ptr         <= '0;
            r_ftw_ack     <= 1'b0;
            r_add_a       <= '0;
            r_add_b       <= '0;
            r_phase_out   <= '0;
            r_phase_ch    <= '0;
            r_phase_valid <= 1'b0;
        end else begin
            // FTW load; an out-of-range channel is acknowledged but dropped.
            // The issue below reads r_ftw before this write lands.
            r_ftw_ack <= w_ftw_take;
            if (w_ftw_take && (int'(ftw_ch) < CH)) begin
                r_ftw[ftw_ch] <= ftw_data;
            end

            for (int k = 1; k <= ADD_LAT; k++) begin
                r_tag_ch[k] <= r_tag_ch[k-1];
            end
            r_tag_ch[0] <= w_sel;

            if (phase_clr) begin
                // Clear wins over writeback and kills every in-flight tag.
                for (int c = 0; c < CH; c++) begin
                    r_phase[c] <= '0;
                end
                r_tag_vld     <= '0;
                r_ptr         <= '0;
                r_phase_valid <= 1'b0;
            end else begin
                r_tag_vld <= {r_tag_vld[ADD_LAT-1:0], w_do_issue};

                r_phase_valid <= w_wb;
                if (w_wb) begin
                    r_phase[w_wb_ch] <= add_sum_in;
                    r_phase_out      <= add_sum_in;
                    r_phase_ch       <= w_wb_ch;
                end

                // Bubbles leave operands and pointer untouched.
                if (w_do_issue) begin
                    r_add_a <= w_op_a;
                    r_add_b <= r_ftw[w_sel];
                    r_ptr   <= (w_sel == c_LAST_CH) ? '0 : w_sel + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_nco_phase_sched
// Description : Self-checking bench for nco_phase_sched. Two instances
//               (CH=4 and CH=2, both ADD_LAT=2) share one stimulus stream
//               and are compared every cycle against a ready-time based
//               reference model; directed sections pin literal values.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_nco_phase_sched;

    localparam int L = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        phase_clr;
    logic        ftw_wr;
    logic [1:0]  ftw_ch;
    logic [31:0] ftw_data;

    logic        ack4, ack2, pv4, pv2;
    logic [31:0] a4, b4, s4, po4, a2, b2, s2, po2;
    logic [1:0]  pch4;
    logic [0:0]  pch2;

    logic [31:0] pipe4 [L];
    logic [31:0] pipe2 [L];

    int checks = 0;
    int errors = 0;

    nco_phase_sched #(.N(32), .CH(4), .CHW(2), .ADD_LAT(L)) dut4 (
        .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr),
        .ftw_wr(ftw_wr), .ftw_ch(ftw_ch), .ftw_data(ftw_data), .ftw_ack(ack4),
        .add_a_out(a4), .add_b_out(b4), .add_sum_in(s4),
        .phase_out(po4), .phase_ch(pch4), .phase_valid(pv4)
    );

    nco_phase_sched #(.N(32), .CH(2), .CHW(1), .ADD_LAT(L)) dut2 (
        .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr),
        .ftw_wr(ftw_wr), .ftw_ch(ftw_ch[0:0]), .ftw_data(ftw_data), .ftw_ack(ack2),
        .add_a_out(a2), .add_b_out(b2), .add_sum_in(s2),
        .phase_out(po2), .phase_ch(pch2), .phase_valid(pv2)
    );

    // External pipelined adders, ADD_LAT register stages.
    always @(posedge clk) begin
        pipe4[0] <= a4 + b4;
        pipe2[0] <= a2 + b2;
        for (int k = 1; k < L; k++) begin
            pipe4[k] <= pipe4[k-1];
            pipe2[k] <= pipe2[k-1];
        end
    end
    assign s4 = pipe4[L-1];
    assign s2 = pipe2[L-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per channel: logical phase, FTW and the first clock edge at which it
    // may be issued again. Results are scheduled by due edge number.
    logic [31:0] mp   [2][4];
    logic [31:0] mf   [2][4];
    int          mrdy [2][4];
    int          mptr [2];
    logic [31:0] ea [2], eb [2], epo [2];
    int          epch [2];
    logic        ev [2], eack [2];
    logic        xv   [2][16];
    logic [31:0] xval [2][16];
    int          xch  [2][16];
    int          mcyc = 0;

    task automatic model_reset(input int m);
        for (int i = 0; i < 4; i++) begin
            mp[m][i] = 0; mf[m][i] = 0; mrdy[m][i] = 0;
        end
        for (int i = 0; i < 16; i++) xv[m][i] = 1'b0;
        mptr[m] = 0; ea[m] = 0; eb[m] = 0; epo[m] = 0; epch[m] = 0;
        ev[m] = 1'b0; eack[m] = 1'b0;
    endtask

    task automatic model_step(input int m);
        int   t, nch, c, sel, wch;
        logic wr_ok;
        t   = mcyc + 1;
        nch = (m == 0) ? 4 : 2;
        if (rst) begin
            model_reset(m);
            return;
        end
        wr_ok   = ftw_wr && !eack[m];
        eack[m] = wr_ok;
        if (phase_clr) begin
            for (int i = 0; i < nch; i++) begin
                mp[m][i] = 0; mrdy[m][i] = 0;
            end
            for (int i = 0; i < 16; i++) xv[m][i] = 1'b0;
            mptr[m] = 0;
            ev[m]   = 1'b0;
        end else begin
            if (xv[m][t % 16]) begin
                ev[m] = 1'b1; epo[m] = xval[m][t % 16]; epch[m] = xch[m][t % 16];
                xv[m][t % 16] = 1'b0;
            end else begin
                ev[m] = 1'b0;
            end
            if (en) begin
                sel = -1;
                for (int i = 0; i < nch; i++) begin
                    c = (mptr[m] + i) % nch;
                    if (sel < 0 && mrdy[m][c] <= t) sel = c;
                end
                if (sel >= 0) begin
                    ea[m] = mp[m][sel];
                    eb[m] = mf[m][sel];
                    mp[m][sel] = mp[m][sel] + mf[m][sel];
                    mrdy[m][sel] = t + L + 1;
                    mptr[m] = (sel + 1) % nch;
                    xv[m][(t + L + 1) % 16]   = 1'b1;
                    xval[m][(t + L + 1) % 16] = mp[m][sel];
                    xch[m][(t + L + 1) % 16]  = sel;
                end
            end
        end
        if (wr_ok) begin
            wch = (m == 0) ? int'(ftw_ch) : int'(ftw_ch[0]);
            if (wch < nch) mf[m][wch] = ftw_data;
        end
    endtask

    task automatic compare(input int m, input logic ack, input logic [31:0] a, input logic [31:0] b,
                           input logic v, input logic [31:0] po, input int pc);
        chk($sformatf("ftw_ack[%0d]", m), ack, eack[m]);
        chk($sformatf("add_a[%0d]", m), a, ea[m]);
        chk($sformatf("add_b[%0d]", m), b, eb[m]);
        chk($sformatf("phase_valid[%0d]", m), v, ev[m]);
        chk($sformatf("phase_out[%0d]", m), po, epo[m]);
        chk($sformatf("phase_ch[%0d]", m), pc, epch[m]);
    endtask

    // Compare on the falling edge, then advance the model to the next edge.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end
            compare(0, ack4, a4, b4, pv4, po4, int'(pch4));
            compare(1, ack2, a2, b2, pv2, po2, int'(pch2));
            model_step(0);
            model_step(1);
            mcyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ftw_write(input logic [1:0] ch, input logic [31:0] data);
        int n;
        ftw_ch = ch; ftw_data = data; ftw_wr = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack4 && n < 10);
        if (!ack4) begin
            checks++; errors++;
            $display("FAIL ftw_ack_timeout got 0 want 1");
        end
        ftw_wr = 1'b0;
        tick();
    endtask

    task automatic pulse_clr();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
    endtask

    initial begin
        int k, nv;
        rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw_wr = 1'b0; ftw_ch = '0; ftw_data = '0;
        repeat (3) tick();

        // First issue after reset is ch0; its result shows ADD_LAT+1 later.
        rst = 1'b0; en = 1'b1;
        repeat (3) tick();
        chk("first_valid_early", pv4, 1'b0);
        tick();
        chk("first_valid", pv4, 1'b1);
        chk("first_valid_ch", pch4, 2'd0);

        ftw_write(2'd0, 32'd1);
        ftw_write(2'd1, 32'd2);
        ftw_write(2'd2, 32'd3);
        ftw_write(2'd3, 32'd4);

        // Clear with ops in flight, then steady rotation.
        pulse_clr();
        chk("clr_no_valid", pv4, 1'b0);
        tick();
        chk("clr_first_a", a4, 32'd0);
        chk("clr_first_b", b4, 32'd1);
        k = 0; nv = 0;
        repeat (40) begin
            tick();
            if (pv4) nv++;
            if (pv4 && pch4 == 2'd2) begin
                k++;
                if (k <= 5) chk("ch2_phase", po4, 32'(3 * k));
            end
        end
        chk("ch2_count", k, 9);
        chk("valid_count", nv, 38);

        // Wrap-around.
        ftw_write(2'd0, 32'h8000_0000);
        pulse_clr();
        k = 0;
        repeat (20) begin
            tick();
            if (pv4 && pch4 == 2'd0) begin
                k++;
                if (k <= 4) chk("wrap_ch0", po4, (k % 2 == 1) ? 32'h8000_0000 : 32'h0);
            end
        end

        // FTW write landing on the ch1 issue edge.
        pulse_clr();
        tick();
        ftw_wr = 1'b1; ftw_ch = 2'd1; ftw_data = 32'h10;
        tick();
        chk("ack_high", ack4, 1'b1);
        ftw_wr = 1'b0;
        tick();
        chk("ack_pulse", ack4, 1'b0);
        k = 0;
        repeat (12) begin
            tick();
            if (pv4 && pch4 == 2'd1) begin
                k++;
                if (k == 1) chk("coll_old_ftw", po4, 32'h2);
                if (k == 2) chk("coll_new_ftw", po4, 32'h12);
            end
        end

        // en=0: drain, then silence.
        en = 1'b0;
        tick();
        chk("drain_valid", pv4, 1'b1);
        repeat (2) tick();
        repeat (5) begin
            tick();
            chk("drained", pv4, 1'b0);
            chk("drained2", pv2, 1'b0);
        end

        // CH=2 bubbles: two updates per three cycles.
        en = 1'b1;
        pulse_clr();
        repeat (3) tick();
        nv = 0;
        repeat (12) begin
            tick();
            if (pv2) nv++;
        end
        chk("bubble_valid_count", nv, 8);

        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        chk("rst_add_a", a4, 32'h0);
        chk("rst_add_b", b4, 32'h0);
        chk("rst_phase_out", po4, 32'h0);
        chk("rst_phase_ch", pch4, 2'd0);
        chk("rst_valid", pv4, 1'b0);
        chk("rst_ack", ack4, 1'b0);
        tick();
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            phase_clr = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            if (ftw_wr) begin
                if (ack4 && $urandom_range(0, 3) != 0) ftw_wr = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                ftw_wr   = 1'b1;
                ftw_ch   = 2'($urandom_range(0, 3));
                ftw_data = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
            end
            tick();
        end

        rst = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw_wr = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
